scalar_alu_seq: RTL and testbench
=================================

Name: scalar_alu_seq

Overview:
- Parametrised, handshaked successor to the combinational scalar ALU in the Execute stage.
- Same opcode map: add, sub, mov, mul, div, cmp, pass-A.
- Adds registered outputs and valid/ready flow control.
- Adds an iterative N-cycle divider, a status-flag output and explicit divide-by-zero reporting, so the Execute stage can stall on long operations.

Parameters:
- N, 16, operand/result width in bits; legal values are 4 to 64.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  A, B and F are valid this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  N  operand A (unsigned, except for flag V).
- B  in  N  operand B.
- F  in  3  opcode: 000 add, 001 sub, 010 mov, 011 mul, 100 div, 101 cmp, 110/111 pass A.
- out_valid  out  1  Result/Flags/div_zero hold a completed operation.
- out_ready  in  1  consumer takes the result this cycle.
- Result  out  N  operation result.
- Flags  out  4  {Z, Neg, C, V}.
- div_zero  out  1  completed op was a div with B==0.
- busy  out  1  divider iterating.

Behaviour:
- Reset: all of the following are forced to 0 in the cycle reset is sampled high, regardless of state, including mid-divide (the in-flight division is discarded).
  - Result, Flags, div_zero, out_valid, busy, iteration counter, quotient/remainder registers.
  - State goes to IDLE.
  - in_ready is 0 during reset and 1 in the first cycle after reset.
- FSM states:
  - IDLE: no operation in flight.
  - DIV: iterating.
  - HOLD: output register full, waiting for the consumer.
- in_ready = (state==IDLE) or (state==HOLD and out_ready). A new operation is accepted on the HOLD-and-out_ready cycle (back-to-back throughput of 1 op/cycle for non-div ops).
- Accept = in_valid and in_ready. A, B and F are captured only on accept.
- Non-div ops, latency 1:
  - On accept, Result/Flags are written at that clock edge, out_valid=1, next state HOLD.
  - add: A+B mod 2^N.
  - sub: A-B mod 2^N.
  - mov: B.
  - mul: low N bits of A*B.
  - cmp: A if (A<B and A!=0), else B (unsigned compare).
  - pass: A.
- div, latency N+1 edges from accept to out_valid:
  - On accept, latch the operands, clear the remainder, counter=0, busy=1, state DIV. If a result is still held (HOLD and out_ready), it is consumed on that same edge and out_valid=0.
  - Each DIV cycle does one restoring step, MSB first: shift the remainder left, bring in the next dividend bit, subtract B if the remainder ≥ B, set the quotient bit.
  - After N steps: Result = quotient, busy=0, out_valid=1, state HOLD.
  - In DIV, in_ready=0 and out_valid=0.
- Divide-by-zero:
  - No iteration: the next edge after accept gives Result = all ones and div_zero=1 (latency 1).
  - State HOLD; Flags are Z=0, Neg=1, C=0, V=0.
- Flags, computed on the final Result:
  - Z = (Result==0).
  - Neg = Result[N-1].
  - C:
    - add: carry-out of the N-bit sum.
    - sub: 1 iff A≥B (no borrow).
    - otherwise 0.
  - V:
    - add: two's-complement overflow.
    - sub: two's-complement overflow.
    - otherwise 0.
  - div_zero is 0 for every op except div with B==0.
- HOLD:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - If out_ready=1 with no accept, next state IDLE, out_valid=0.
  - If out_ready=1 with a simultaneous accept, outputs are replaced (non-div) or cleared and the block enters DIV.
- in_valid while in_ready=0: ignored. The producer must hold its request.
- out_ready while out_valid=0: no effect.

Test Plan:
- N=16, reset then add A=16'hFFFF, B=16'h0001, out_ready=1 → one cycle later out_valid=1, Result=16'h0000, Flags Z=1, Neg=0, C=1, V=0.
- sub A=16'h8000, B=16'h0001 → Result=16'h7FFF, Z=0, Neg=0, C=1, V=1; then cmp A=0, B=5 → Result=5; cmp A=3, B=5 → Result=3.
- div A=100, B=7, out_ready=1 → in_ready=0 and busy=1 for 16 cycles, out_valid on the 17th edge after accept, Result=14, div_zero=0.
- div A=42, B=0 → next edge: Result=16'hFFFF, div_zero=1, out_valid=1, no busy cycles.
- Backpressure: mul A=300, B=300 with out_ready=0 for 5 cycles, new in_valid ops presented → Result stays 16'h5F90, in_ready=0, new ops not accepted; raise out_ready together with in_valid (mov B=9) → next cycle Result=9.
- Reset asserted on the 8th cycle of a div A=1000, B=3 → next cycle out_valid=0, busy=0, in_ready=1; a fresh add 2+3 then yields Result=5.

Source files
------------

// File: rtl/scalar_alu_seq.sv
// Handshaked scalar ALU for the Execute stage: registered add/sub/mov/mul/cmp/pass
// results with flags, plus an iterative restoring divider that stalls the producer.
module scalar_alu_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   F,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic [3:0]   Flags,
  output logic         div_zero,
  output logic         busy
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  state_t        state, state_n;
  logic [N-1:0]  res_n;
  logic [3:0]    flags_n;
  logic          dz_n, ov_n, busy_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  quo, quo_n, rem, rem_n, dvs, dvs_n;
  logic          accept;
  logic [N:0]    rem_sh;
  logic          step_ge;
  logic [N-1:0]  rem_step, quo_step;

  function automatic logic [N-1:0] alu(input logic [2:0] op, input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MOV:  return b;
      OP_MUL:  return a * b;
      OP_CMP:  return (a < b && a != '0) ? a : b;
      default: return a;
    endcase
  endfunction

  // Carry on add is recovered from wrap-around of the truncated sum.
  function automatic logic [3:0] calc_flags(input logic [2:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic [N-1:0] r);
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        c = (r < a);
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        c = (a >= b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      default: ;
    endcase
    return {r == '0, r[N-1], c, v};
  endfunction

  assign in_ready = !reset && (state == IDLE || (state == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  // One restoring step: quo shifts the dividend out MSB-first and the quotient in.
  assign rem_sh   = {rem, quo[N-1]};
  assign step_ge  = rem_sh >= {1'b0, dvs};
  assign rem_step = step_ge ? rem_sh[N-1:0] - dvs : rem_sh[N-1:0];
  assign quo_step = {quo[N-2:0], step_ge};

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    res_n   = Result;
    flags_n = Flags;
    dz_n    = div_zero;
    ov_n    = out_valid;
    busy_n  = busy;
    cnt_n   = cnt;
    quo_n   = quo;
    rem_n   = rem;
    dvs_n   = dvs;

    if (state == DIV) begin
      quo_n = quo_step;
      rem_n = rem_step;
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(N - 1)) begin
        res_n   = quo_step;
        flags_n = calc_flags(OP_DIV, quo_step, dvs, quo_step);
        busy_n  = 1'b0;
        ov_n    = 1'b1;
        cnt_n   = '0;
        state_n = HOLD;
      end
    end else if (accept) begin
      if (F == OP_DIV && B == '0) begin
        res_n   = '1;
        flags_n = calc_flags(OP_DIV, A, B, '1);
        dz_n    = 1'b1;
        ov_n    = 1'b1;
        state_n = HOLD;
      end else if (F == OP_DIV) begin
        res_n   = '0;
        flags_n = '0;
        dz_n    = 1'b0;
        ov_n    = 1'b0;
        busy_n  = 1'b1;
        cnt_n   = '0;
        quo_n   = A;
        rem_n   = '0;
        dvs_n   = B;
        state_n = DIV;
      end else begin
        res_n   = alu(F, A, B);
        flags_n = calc_flags(F, A, B, alu(F, A, B));
        dz_n    = 1'b0;
        ov_n    = 1'b1;
        state_n = HOLD;
      end
    end else if (state == HOLD && out_ready) begin
      ov_n    = 1'b0;
      state_n = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      Result    <= '0;
      Flags     <= '0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
    end else begin
      state     <= state_n;
      Result    <= res_n;
      Flags     <= flags_n;
      div_zero  <= dz_n;
      out_valid <= ov_n;
      busy      <= busy_n;
      cnt       <= cnt_n;
      quo       <= quo_n;
      rem       <= rem_n;
      dvs       <= dvs_n;
    end
  end

endmodule

// File: tb/tb_scalar_alu_seq.sv
// Self-checking bench for scalar_alu_seq (N=16): vector table, handshake corner
// sequences and randomized ops against an arithmetic reference model.
module tb_scalar_alu_seq;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B;
  logic [2:0]   F;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Result;
  logic [3:0]   Flags;
  logic         div_zero;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  scalar_alu_seq #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .F        (F),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .Flags    (Flags),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flags;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic void model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] fl, output logic dz);
    int     sa, sb, t;
    longint lt;
    logic   c, v;
    sa = $signed(a);
    sb = $signed(b);
    c  = 1'b0;
    v  = 1'b0;
    dz = 1'b0;
    case (f)
      3'd0: begin
        t = int'(a) + int'(b);
        r = t[15:0];
        c = (t > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      3'd2: r = b;
      3'd3: begin
        lt = longint'(a) * longint'(b);
        r  = lt[15:0];
      end
      3'd4: begin
        if (b == 0) begin
          r  = 16'hFFFF;
          dz = 1'b1;
        end else begin
          r = a / b;
        end
      end
      3'd5: r = (a < b && a != 0) ? a : b;
      default: r = a;
    endcase
    fl = {r == 0, r[15], c, v};
  endfunction

  // Presents one op with out_ready=1, returns the completed outputs and edge latency.
  task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic [3:0] fl, output logic dz,
                        output int lat);
    int k;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    F = f;
    A = a;
    B = b;
    k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    r  = Result;
    fl = Flags;
    dz = div_zero;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, er;
    logic [3:0]  fl, efl;
    logic        dz, edz;
    int          lat, cnt16;

    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0, 1};
    vecs[2]  = '{3'd5, 16'h0000, 16'h0005, 16'h0005, 4'b0000, 1'b0, 1};
    vecs[3]  = '{3'd5, 16'h0003, 16'h0005, 16'h0003, 4'b0000, 1'b0, 1};
    vecs[4]  = '{3'd3, 16'd300,  16'd300,  16'h5F90, 4'b0000, 1'b0, 1};
    vecs[5]  = '{3'd2, 16'h1234, 16'h0009, 16'h0009, 4'b0000, 1'b0, 1};
    vecs[6]  = '{3'd6, 16'h8001, 16'h0003, 16'h8001, 4'b0100, 1'b0, 1};
    vecs[7]  = '{3'd7, 16'h0000, 16'h0003, 16'h0000, 4'b1000, 1'b0, 1};
    vecs[8]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1};
    vecs[9]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 1'b0, 1};
    vecs[10] = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1'b0, 1};
    vecs[11] = '{3'd4, 16'd100,  16'd7,    16'd14,   4'b0000, 1'b0, 17};
    vecs[12] = '{3'd4, 16'd42,   16'd0,    16'hFFFF, 4'b0100, 1'b1, 1};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    F = '0;
    tick();
    tick();
    check("rst_result", 64'(Result), 64'd0);
    check("rst_flags", 64'(Flags), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, fl, dz, lat);
      check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'(fl), 64'(vecs[i].flags));
      check($sformatf("vec%0d_div_zero", i), 64'(dz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Divider occupancy: busy high and producer stalled for N cycles.
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1;
    F = 3'd4;
    A = 16'd100;
    B = 16'd7;
    check("div_in_ready_before", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    cnt16 = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy && !in_ready && !out_valid) cnt16++;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("div_busy_cycles", 64'(cnt16), 64'd16);
    check("div_done_valid", 64'(out_valid), 64'd1);
    check("div_done_busy", 64'(busy), 64'd0);
    check("div_done_result", 64'(Result), 64'd14);

    // Divide by zero never raises busy.
    run_op(3'd4, 16'd42, 16'd0, r, fl, dz, lat);
    check("dz_busy", 64'(busy), 64'd0);
    check("dz_result", 64'(r), 64'hFFFF);

    // Backpressure: held result must not change and new ops must not be taken.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    F = 3'd3;
    A = 16'd300;
    B = 16'd300;
    tick();
    for (int i = 0; i < 5; i++) begin
      F = 3'd0;
      A = 16'd1;
      B = 16'd1;
      check($sformatf("bp%0d_result", i), 64'(Result), 64'h5F90);
      check($sformatf("bp%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    F = 3'd2;
    B = 16'd9;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_mov_result", 64'(Result), 64'd9);
    check("bp_mov_valid", 64'(out_valid), 64'd1);

    // Reset in the middle of a division discards it.
    in_valid = 1'b1;
    F = 3'd4;
    A = 16'd1000;
    B = 16'd3;
    #1;
    check("rdiv_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("rdiv_busy_mid", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rdiv_in_ready_in_reset", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rdiv_out_valid", 64'(out_valid), 64'd0);
    check("rdiv_busy", 64'(busy), 64'd0);
    check("rdiv_in_ready", 64'(in_ready), 64'd1);
    run_op(3'd0, 16'd2, 16'd3, r, fl, dz, lat);
    check("rdiv_add_result", 64'(r), 64'd5);

    // Randomized back-to-back ops against the model.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  rf;
      logic [15:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 16'd0 :
           ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom);
      model(rf, ra, rb, er, efl, edz);
      run_op(rf, ra, rb, r, fl, dz, lat);
      check($sformatf("rnd%0d_f%0d_result", i, rf), 64'(r), 64'(er));
      check($sformatf("rnd%0d_f%0d_flags", i, rf), 64'(fl), 64'(efl));
      check($sformatf("rnd%0d_f%0d_div_zero", i, rf), 64'(dz), 64'(edz));
      check($sformatf("rnd%0d_f%0d_latency", i, rf), 64'(lat),
            (rf == 3'd4 && rb != 0) ? 64'd17 : 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
